// File: rtl/pong_input_ctrl_if.sv
// Signal bundle between the board pins / game core and the player-input front end.
// The slave modport is the controller's view; the master modport drives buttons and status.
interface pong_input_ctrl_if;
  logic       btn_up_p1;
  logic       btn_down_p1;
  logic       btn_up_p2;
  logic       btn_down_p2;
  logic       game_startup;
  logic       game_over;
  logic       up_p1;
  logic       down_p1;
  logic       up_p2;
  logic       down_p2;
  logic [1:0] mode_choice;
  logic       start_trigger;
  logic [1:0] ctrl_state;

  modport master (
    output btn_up_p1, btn_down_p1, btn_up_p2, btn_down_p2,
    output game_startup, game_over,
    input  up_p1, down_p1, up_p2, down_p2,
    input  mode_choice, start_trigger, ctrl_state
  );

  modport slave (
    input  btn_up_p1, btn_down_p1, btn_up_p2, btn_down_p2,
    input  game_startup, game_over,
    output up_p1, down_p1, up_p2, down_p2,
    output mode_choice, start_trigger, ctrl_state
  );
endinterface

// File: rtl/pong_input_ctrl.sv
// Player-control front end: synchronises and debounces four active-low buttons and runs the
// menu / game-over input FSM that produces mode_choice and the one-cycle start_trigger pulse.
module pong_input_ctrl #(
  parameter int DEBOUNCE_CYCLES = 250_000,
  parameter int LOCKOUT_CYCLES  = 2_500_000,
  parameter int CNT_W           = 22
) (
  input  logic              clk_0,
  input  logic              rst,
  pong_input_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_LOCKOUT = 2'd0,
    ST_MENU    = 2'd1,
    ST_PLAYING = 2'd2,
    ST_OVER    = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCKOUT_CYCLES - 1);

  // Bit order everywhere: [3] up_p1, [2] down_p1, [1] up_p2, [0] down_p2
  logic [3:0] raw_btn;
  logic [3:0] deb_level;
  logic [3:0] press;

  assign raw_btn = {bus.btn_up_p1, bus.btn_down_p1, bus.btn_up_p2, bus.btn_down_p2};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_btn
      logic             sync1_reg;
      logic             sync2_reg;
      logic             deb_reg;
      logic             deb_prev_reg;
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk_0 or negedge rst) begin
        if (!rst) begin
          sync1_reg    <= 1'b1;
          sync2_reg    <= 1'b1;
          deb_reg      <= 1'b1;
          deb_prev_reg <= 1'b1;
          cnt_reg      <= '0;
        end else begin
          sync1_reg    <= raw_btn[gi];
          sync2_reg    <= sync1_reg;
          deb_prev_reg <= deb_reg;
          // Any return to the settled level restarts the stability count
          if (sync2_reg == deb_reg) begin
            cnt_reg <= '0;
          end else if (cnt_reg == DEB_LAST) begin
            deb_reg <= sync2_reg;
            cnt_reg <= '0;
          end else begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end
      end

      assign deb_level[gi] = deb_reg;
      assign press[gi]     = deb_prev_reg & ~deb_reg;
    end
  endgenerate

  assign bus.up_p1   = deb_level[3];
  assign bus.down_p1 = deb_level[2];
  assign bus.up_p2   = deb_level[1];
  assign bus.down_p2 = deb_level[0];

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] lock_cnt_reg, lock_cnt_next;
  logic [1:0]       mode_reg, mode_next;
  logic             start_reg, start_next;
  logic             startup_d_reg;
  logic             startup_rise;

  assign startup_rise = bus.game_startup & ~startup_d_reg;

  always_ff @(posedge clk_0 or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_LOCKOUT;
      lock_cnt_reg  <= '0;
      mode_reg      <= 2'd0;
      start_reg     <= 1'b0;
      startup_d_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      lock_cnt_reg  <= lock_cnt_next;
      mode_reg      <= mode_next;
      start_reg     <= start_next;
      startup_d_reg <= bus.game_startup;
    end
  end

  // Lockout counter only advances inside LOCKOUT, so every entry starts from zero
  always_comb begin
    state_next    = state_reg;
    lock_cnt_next = '0;
    mode_next     = mode_reg;
    start_next    = 1'b0;
    case (state_reg)
      ST_LOCKOUT: begin
        if (lock_cnt_reg == LOCK_LAST) begin
          if (bus.game_over) begin
            state_next = ST_OVER;
          end else if (bus.game_startup) begin
            state_next = ST_MENU;
          end else begin
            state_next = ST_PLAYING;
          end
        end else begin
          lock_cnt_next = lock_cnt_reg + CNT_W'(1);
        end
      end
      ST_MENU: begin
        if (press[3]) begin
          mode_next  = 2'd1;
          start_next = 1'b1;
          state_next = ST_PLAYING;
        end else if (press[2]) begin
          mode_next  = 2'd2;
          start_next = 1'b1;
          state_next = ST_PLAYING;
        end
      end
      ST_PLAYING: begin
        if (bus.game_over || bus.game_startup) begin
          state_next = ST_LOCKOUT;
        end
      end
      ST_OVER: begin
        if (startup_rise) begin
          state_next = ST_LOCKOUT;
        end else if (|press) begin
          start_next = 1'b1;
          state_next = ST_PLAYING;
        end
      end
      default: begin
        state_next = ST_LOCKOUT;
      end
    endcase
  end

  assign bus.mode_choice   = mode_reg;
  assign bus.start_trigger = start_reg;
  assign bus.ctrl_state    = state_reg;

endmodule
